// File: rtl/conv_pad_feeder.sv
// ---------------------------------------------------------------------------
// conv_pad_feeder
//   Turns an unpadded W x H RGB raster (valid/ready handshake) into the
//   (W+2) x (H+2) zero-padded beat stream consumed by the 3x3 conv core.
//   At most one beat per cycle; the conv side never backpressures.
//
// Optional feature macro: CONV_FEED_STALL_CNT_EN
//   When defined, adds output stall_cnt[15:0]. It counts the cycles spent
//   waiting on an interior pixel with din_valid low. It clears on the sof_out
//   beat and saturates at 16'hFFFF.
//
// Ports
//   clk                 rising-edge clock
//   Rst                 synchronous active-high reset
//   din_r/g/b [M-1:0]   upstream pixel channels
//   din_sof             upstream first-pixel-of-frame marker
//   din_valid           upstream pixel valid
//   din_ready           pixel accepted this cycle (combinational)
//   dout_r/g/b [M-1:0]  padded pixel, zero on padding beats (registered)
//   valid_out           beat valid (registered)
//   repeat_out          beat is border padding (registered)
//   sof_out             beat is row 0 / col 0 (registered)
//   eol_out             beat is col W+1 of its row (registered)
//   frame_done          one-cycle pulse after the last beat (registered)
//   err_sof             sticky: din_sof seen on a non-first accepted pixel
//   stall_cnt [15:0]    interior starvation cycles (macro builds only)
// ---------------------------------------------------------------------------
module conv_pad_feeder #(
  parameter int M = 8,
  parameter int W = 480,
  parameter int H = 480
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic [M-1:0] din_r,
  input  logic [M-1:0] din_g,
  input  logic [M-1:0] din_b,
  input  logic         din_sof,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [M-1:0] dout_r,
  output logic [M-1:0] dout_g,
  output logic [M-1:0] dout_b,
  output logic         valid_out,
  output logic         repeat_out,
  output logic         sof_out,
  output logic         eol_out,
  output logic         frame_done,
`ifdef CONV_FEED_STALL_CNT_EN
  output logic         err_sof,
  output logic [15:0]  stall_cnt
`else
  output logic         err_sof
`endif
);

  localparam int CW = $clog2(W + 2);
  localparam int RW = $clog2(H + 2);

  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(W + 1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_H    = RW'(H);
  localparam logic [RW-1:0] ROW_LAST = RW'(H + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP    = 3'd1,
    ST_ROW    = 3'd2,
    ST_BOTTOM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] col_r, col_s;
  logic [RW-1:0] row_r, row_s;

  // Beat generated this cycle; it is registered onto the outputs next edge.
  logic beat_valid_s;
  logic beat_pad_s;
  logic beat_sof_s;
  logic beat_eol_s;
  logic beat_done_s;
  logic pix_acc_s;
  logic err_set_s;
  logic stall_inc_s;
  logic col_last_s;
  logic col_pad_s;

  assign col_last_s = (col_r == COL_LAST);
  assign col_pad_s  = (col_r == COL_ZERO) || col_last_s;

  // Next-state, counter advance and beat generation.
  always_comb begin
    state_s      = state_r;
    col_s        = col_r;
    row_s        = row_r;
    din_ready    = 1'b0;
    beat_valid_s = 1'b0;
    beat_pad_s   = 1'b0;
    beat_sof_s   = 1'b0;
    beat_eol_s   = 1'b0;
    beat_done_s  = 1'b0;
    pix_acc_s    = 1'b0;
    err_set_s    = 1'b0;
    stall_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The sof pixel is left on the bus; it is consumed at row 1, col 1.
        if (din_valid && din_sof) begin
          state_s = ST_TOP;
          col_s   = COL_ZERO;
          row_s   = ROW_ZERO;
        end else begin
          din_ready = din_valid;
        end
      end
      ST_TOP: begin
        beat_valid_s = 1'b1;
        beat_pad_s   = 1'b1;
        beat_sof_s   = (col_r == COL_ZERO);
        beat_eol_s   = col_last_s;
        if (col_last_s) begin
          state_s = ST_ROW;
          col_s   = COL_ZERO;
          row_s   = ROW_ONE;
        end else begin
          col_s = col_r + COL_ONE;
        end
      end
      ST_ROW: begin
        if (col_pad_s) begin
          beat_valid_s = 1'b1;
          beat_pad_s   = 1'b1;
          beat_eol_s   = col_last_s;
          if (col_last_s) begin
            col_s = COL_ZERO;
            if (row_r == ROW_H) begin
              state_s = ST_BOTTOM;
              row_s   = ROW_LAST;
            end else begin
              row_s = row_r + ROW_ONE;
            end
          end else begin
            col_s = col_r + COL_ONE;
          end
        end else begin
          din_ready = 1'b1;
          if (din_valid) begin
            beat_valid_s = 1'b1;
            pix_acc_s    = 1'b1;
            col_s        = col_r + COL_ONE;
            // The first pixel may legitimately repeat the sof seen in IDLE.
            err_set_s    = din_sof && !((row_r == ROW_ONE) && (col_r == COL_ONE));
          end else begin
            stall_inc_s = 1'b1;
          end
        end
      end
      ST_BOTTOM: begin
        beat_valid_s = 1'b1;
        beat_pad_s   = 1'b1;
        beat_eol_s   = col_last_s;
        if (col_last_s) begin
          state_s = ST_DONE;
          col_s   = COL_ZERO;
          row_s   = ROW_ZERO;
        end else begin
          col_s = col_r + COL_ONE;
        end
      end
      ST_DONE: begin
        beat_done_s = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        col_s   = COL_ZERO;
        row_s   = ROW_ZERO;
      end
    endcase
  end

  // State and raster position registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      col_r   <= COL_ZERO;
      row_r   <= ROW_ZERO;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Registered beat outputs and sticky sof error.
  always_ff @(posedge clk) begin
    if (Rst) begin
      dout_r     <= {M{1'b0}};
      dout_g     <= {M{1'b0}};
      dout_b     <= {M{1'b0}};
      valid_out  <= 1'b0;
      repeat_out <= 1'b0;
      sof_out    <= 1'b0;
      eol_out    <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      dout_r     <= pix_acc_s ? din_r : {M{1'b0}};
      dout_g     <= pix_acc_s ? din_g : {M{1'b0}};
      dout_b     <= pix_acc_s ? din_b : {M{1'b0}};
      valid_out  <= beat_valid_s;
      repeat_out <= beat_pad_s;
      sof_out    <= beat_sof_s;
      eol_out    <= beat_eol_s;
      frame_done <= beat_done_s;
      err_sof    <= err_sof | err_set_s;
    end
  end

`ifdef CONV_FEED_STALL_CNT_EN
  // Interior starvation counter; restarts with each frame's sof beat.
  always_ff @(posedge clk) begin
    if (Rst) begin
      stall_cnt <= 16'h0000;
    end else if (beat_sof_s) begin
      stall_cnt <= 16'h0000;
    end else if (stall_inc_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_conv_pad_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_pad_feeder
//   Self-checking bench for conv_pad_feeder at W=4, H=3. The expected padded
//   stream is built from the list of pixels sent, by walking the padded
//   raster; it is compared beat by beat against a monitor capture.
// ---------------------------------------------------------------------------
module tb_conv_pad_feeder;

  localparam int M  = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NB = (W + 2) * (H + 2);
  localparam int NP = W * H;

  logic         clk;
  logic         Rst;
  logic [M-1:0] din_r, din_g, din_b;
  logic         din_sof, din_valid, din_ready;
  logic [M-1:0] dout_r, dout_g, dout_b;
  logic         valid_out, repeat_out, sof_out, eol_out, frame_done, err_sof;
`ifdef CONV_FEED_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  conv_pad_feeder #(.M(M), .W(W), .H(H)) dut (
    .clk(clk), .Rst(Rst),
    .din_r(din_r), .din_g(din_g), .din_b(din_b),
    .din_sof(din_sof), .din_valid(din_valid), .din_ready(din_ready),
    .dout_r(dout_r), .dout_g(dout_g), .dout_b(dout_b),
    .valid_out(valid_out), .repeat_out(repeat_out), .sof_out(sof_out),
    .eol_out(eol_out), .frame_done(frame_done),
`ifdef CONV_FEED_STALL_CNT_EN
    .err_sof(err_sof), .stall_cnt(stall_cnt)
`else
    .err_sof(err_sof)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    logic        rep;
    logic        sof;
    logic        eol;
    int          cyc;
  } beat_t;

  typedef struct {
    logic vld;
    logic sof;
    logic exp_ready;
  } idle_vec_t;

  beat_t got_q[$];
  int    done_q[$];
  int    cyc_cnt = 0;
  int    checks = 0;
  int    failures = 0;

  // Capture every output beat and frame_done pulse with its cycle number.
  always @(negedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (valid_out) got_q.push_back('{{dout_r, dout_g, dout_b}, repeat_out, sof_out, eol_out, cyc_cnt});
    if (frame_done) done_q.push_back(cyc_cnt);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Runs one frame. vmode: 0 continuous, 1 toggle, 2 random. err_idx: pixel
  // index carrying an illegal sof (-1 none). abort_at: beat count at which
  // Rst is pulsed (0 none).
  task automatic do_frame(input int nstray, input int vmode, input int err_idx, input int abort_at);
    logic [23:0] pix [NP];
    beat_t       exp_q[$];
    int          idx = 0;
    int          cyc = 0;
    bit          acc, vld;
    bit          chk_next = 1'b0;
    int          span;
    for (int i = 0; i < NP; i++) pix[i] = 24'($urandom);
    @(posedge clk); #1;
    got_q.delete();
    done_q.delete();
    for (int s = 0; s < nstray; s++) begin
      din_valid = 1'b1; din_sof = 1'b0; {din_r, din_g, din_b} = 24'hEEEEEE;
      @(negedge clk); #1;
      chk("stray_ready", 64'(din_ready), 64'd1);
      @(posedge clk); #1;
    end
    while (idx < NP && cyc < 500) begin
      case (vmode)
        0: vld = 1'b1;
        1: vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 99) < 60);
      endcase
      din_valid = vld;
      {din_r, din_g, din_b} = pix[idx];
      din_sof = vld && (idx == 0 || idx == err_idx);
      @(negedge clk); #1;
      if (chk_next) chk("err_sof_set", 64'(err_sof), 64'd1);
      chk_next = 1'b0;
      if (abort_at > 0 && got_q.size() == abort_at) begin
        Rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0;
        @(negedge clk); #1;
        chk("abort_outputs", 64'({valid_out, repeat_out, sof_out, eol_out, frame_done, err_sof,
                                  dout_r, dout_g, dout_b}), 64'd0);
        chk("abort_ready", 64'(din_ready), 64'd0);
        @(posedge clk); #1;
        Rst = 1'b0;
        return;
      end
      acc = din_valid && din_ready;
      if (acc && idx == err_idx) begin
        chk("err_sof_before", 64'(err_sof), 64'd0);
        chk_next = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    din_valid = 1'b0; din_sof = 1'b0;
    chk("pixels_timeout", 64'(idx), 64'(NP));
    for (int k = 0; k < 100 && done_q.size() == 0; k++) begin
      @(negedge clk); #1;
      if (chk_next) chk("err_sof_set", 64'(err_sof), 64'd1);
      chk_next = 1'b0;
    end
    chk("done_seen", 64'(done_q.size()), 64'd1);
    // Expected stream: walk the padded raster, borders are zero padding.
    for (int r = 0; r < H + 2; r++)
      for (int c = 0; c < W + 2; c++) begin
        bit brd;
        brd = (r == 0 || r == H + 1 || c == 0 || c == W + 1);
        exp_q.push_back('{brd ? 24'h0 : pix[(r - 1) * W + c - 1], brd, (r == 0 && c == 0),
                          (c == W + 1), 0});
      end
    chk("beat_count", 64'(got_q.size()), 64'(NB));
    for (int i = 0; i < NB && i < got_q.size(); i++)
      chk($sformatf("beat%0d", i), 64'({got_q[i].px, got_q[i].rep, got_q[i].sof, got_q[i].eol}),
          64'({exp_q[i].px, exp_q[i].rep, exp_q[i].sof, exp_q[i].eol}));
    if (got_q.size() > 0 && done_q.size() > 0) begin
      span = got_q[got_q.size() - 1].cyc - got_q[0].cyc + 1;
      chk("done_after_last", 64'(done_q[0] - got_q[got_q.size() - 1].cyc), 64'd1);
      if (vmode == 0) chk("continuous_span", 64'(span), 64'(NB));
`ifdef CONV_FEED_STALL_CNT_EN
      // Each cycle without a beat inside the frame is an interior stall.
      chk("stall_cnt", 64'(stall_cnt), 64'(span - got_q.size()));
`endif
    end
  endtask

  initial begin
    idle_vec_t tbl[5];
    tbl[0] = '{1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0};

    Rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0;
    din_r = 8'h00; din_g = 8'h00; din_b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", 64'({valid_out, repeat_out, sof_out, eol_out, frame_done, err_sof,
                              dout_r, dout_g, dout_b}), 64'd0);
    chk("reset_ready", 64'(din_ready), 64'd0);
`ifdef CONV_FEED_STALL_CNT_EN
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    Rst = 1'b0;

    // IDLE handshake table: only stray (non-sof) pixels are taken.
    for (int i = 0; i < 5; i++) begin
      din_valid = tbl[i].vld; din_sof = tbl[i].sof;
      {din_r, din_g, din_b} = 24'h123456;
      #1;
      chk($sformatf("idle_ready%0d", i), 64'(din_ready), 64'(tbl[i].exp_ready));
      @(negedge clk); #1;
      chk($sformatf("idle_novalid%0d", i), 64'(valid_out), 64'd0);
      @(posedge clk); #1;
    end
    din_valid = 1'b0; din_sof = 1'b0;

    do_frame(0, 0, -1, 0);   // continuous
    do_frame(0, 1, -1, 0);   // toggling valid
    do_frame(3, 0, -1, 0);   // stray pixels first
    chk("err_sof_clear", 64'(err_sof), 64'd0);
    do_frame(0, 0, 5, 0);    // sof on pixel 6
    do_frame(0, 2, -1, 0);
    chk("err_sof_hold", 64'(err_sof), 64'd1);
    do_frame(0, 0, -1, 14);  // reset at beat 14
    chk("err_sof_after_rst", 64'(err_sof), 64'd0);
    do_frame(0, 0, -1, 0);   // clean frame after abort
    for (int f = 0; f < 4; f++) do_frame(int'($urandom_range(0, 2)), 2, -1, 0);
    chk("err_sof_final", 64'(err_sof), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
